// File: rtl/alu_share_arb.sv
// Shares one 32-bit combinational alu among NUM_REQ requesters with a single-entry response buffer.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).

module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] y
);
    always_comb begin
        y = '0;
        case (op)
            4'd0: y = a + b;
            4'd1: y = a - b;
            4'd2: y = {31'b0, $signed(a) < $signed(b)};
            4'd3: y = {31'b0, a < b};
            4'd4: y = a ^ b;
            4'd5: y = a | b;
            4'd6: y = a & b;
            4'd7: y = a << b[4:0];
            4'd8: y = a >> b[4:0];
            4'd9: y = $signed(a) >>> b[4:0];
            default: y = '0;
        endcase
    end
endmodule

module alu_share_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    output logic [NUM_REQ-1:0]    o_req_ready,
    input  logic [NUM_REQ*32-1:0] i_req_operand_a,
    input  logic [NUM_REQ*32-1:0] i_req_operand_b,
    input  logic [NUM_REQ*4-1:0]  i_req_alu_op,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [31:0]           o_rsp_data,
    output logic [ID_W-1:0]       o_rsp_id,
    output logic                  o_rsp_illegal,
    output logic                  o_busy
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t state;

    logic [31:0]         req_a  [NUM_REQ];
    logic [31:0]         req_b  [NUM_REQ];
    logic [3:0]          req_op [NUM_REQ];

    logic [31:0]         iss_a;
    logic [31:0]         iss_b;
    logic [3:0]          iss_op;
    logic [ID_W-1:0]     iss_id;
    logic [31:0]         alu_y;

    logic [ID_W-1:0]     base;
    logic [ID_W-1:0]     idx;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_found;
    logic [NUM_REQ-1:0]  grant;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_a[k]  = i_req_operand_a[32*k+31:32*k];
        assign req_b[k]  = i_req_operand_b[32*k+31:32*k];
        assign req_op[k] = i_req_alu_op[4*k+3:4*k];
    end

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr;
    assign base = rr_ptr;
`else
    assign base = '0;
`endif

    // Search starts at base and wraps modulo NUM_REQ; first valid requester wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        idx         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((32'(base) + i) % NUM_REQ);
            if (!grant_found && i_req_valid[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = idx;
                grant_found = 1'b1;
            end
        end
    end

    assign o_req_ready = (state == S_IDLE) ? grant : '0;
    assign o_busy      = (state != S_IDLE);

    alu u_alu (
        .a  (iss_a),
        .b  (iss_b),
        .op (iss_op),
        .y  (alu_y)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= S_IDLE;
            iss_a         <= '0;
            iss_b         <= '0;
            iss_op        <= '0;
            iss_id        <= '0;
            o_rsp_valid   <= 1'b0;
            o_rsp_data    <= '0;
            o_rsp_id      <= '0;
            o_rsp_illegal <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            rr_ptr        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        iss_a  <= req_a[grant_idx];
                        iss_b  <= req_b[grant_idx];
                        iss_op <= req_op[grant_idx];
                        iss_id <= grant_idx;
                        state  <= S_EXEC;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                        rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
                    end
                end
                S_EXEC: begin
                    o_rsp_data    <= alu_y;
                    o_rsp_id      <= iss_id;
                    o_rsp_illegal <= (iss_op > 4'd9);
                    o_rsp_valid   <= 1'b1;
                    state         <= S_RESP;
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed vectors plus a per-cycle transaction-level reference model.
module tb_alu_share_arb;
    localparam int NR = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NR-1:0]         valid;
    logic [NR-1:0][31:0]   opa;
    logic [NR-1:0][31:0]   opb;
    logic [NR-1:0][3:0]    opc;
    logic [NR-1:0]         ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_data;
    logic [1:0]            rsp_id;
    logic                  rsp_ill;
    logic                  busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.NUM_REQ(NR), .ID_W(2)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_req_valid     (valid),
        .o_req_ready     (ready),
        .i_req_operand_a (opa),
        .i_req_operand_b (opb),
        .i_req_alu_op    (opc),
        .o_rsp_valid     (rsp_valid),
        .i_rsp_ready     (rsp_ready),
        .o_rsp_data      (rsp_data),
        .o_rsp_id        (rsp_id),
        .o_rsp_illegal   (rsp_ill),
        .o_busy          (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for the DUT at %0t", nm, $time);
    endtask

    // Reference: what an operation must produce, from the opcode table.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        int unsigned sh;
        logic signed [31:0] sa;
        sh = int'(b[4:0]);
        sa = a;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return (sa < $signed(b)) ? 32'd1 : 32'd0;
            4'd3: return (a < b) ? 32'd1 : 32'd0;
            4'd4: return a ^ b;
            4'd5: return a | b;
            4'd6: return a & b;
            4'd7: return a << sh;
            4'd8: return a >> sh;
            4'd9: return 32'(sa >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_grant(input logic [NR-1:0] v, input int ptr);
        for (int i = 0; i < NR; i++)
            if (v[(ptr + i) % NR]) return (ptr + i) % NR;
        return -1;
    endfunction

    // Model: phase 0 = free, 1 = evaluating, 2 = response pending.
    int          m_phase = 0;
    int          m_ptr   = 0;
    logic [31:0] m_data;
    int          m_id;
    logic        m_ill;
    int          g;

    always @(negedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_ptr   = 0;
            chk("model_reset_zero",
                rsp_data | 32'(ready) | 32'(rsp_id) | {29'b0, rsp_valid, rsp_ill, busy}, 32'd0);
        end else begin
            g = model_grant(valid, m_ptr);
            chk("model_req_ready", 32'(ready), (m_phase == 0 && g >= 0) ? 32'(1 << g) : 32'd0);
            chk("model_busy", 32'(busy), (m_phase != 0) ? 32'd1 : 32'd0);
            chk("model_rsp_valid", 32'(rsp_valid), (m_phase == 2) ? 32'd1 : 32'd0);
            if (m_phase == 2) begin
                chk("model_rsp_data", rsp_data, m_data);
                chk("model_rsp_id", 32'(rsp_id), 32'(m_id));
                chk("model_rsp_illegal", 32'(rsp_ill), 32'(m_ill));
            end
            case (m_phase)
                0: if (g >= 0) begin
                    m_data  = ref_alu(opa[g], opb[g], opc[g]);
                    m_id    = g;
                    m_ill   = (opc[g] > 4'd9);
`ifdef ALU_ARB_ROUND_ROBIN_EN
                    m_ptr   = (g + 1) % NR;
`endif
                    m_phase = 1;
                end
                1: m_phase = 2;
                default: if (rsp_ready) m_phase = 0;
            endcase
        end
    end

    task automatic clear_reqs();
        valid = '0;
        opa   = '0;
        opb   = '0;
        opc   = '0;
    endtask

    task automatic wait_ready(input int k, input string nm, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (ready[k]) ok = 1'b1;
        end
        if (!ok) tmo(nm);
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) tmo(nm);
    endtask

    task automatic single(input int k, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input logic [31:0] exp_d, input logic exp_ill, input string nm);
        bit ok;
        @(posedge clk); #1;
        clear_reqs();
        valid[k] = 1'b1;
        opa[k]   = a;
        opb[k]   = b;
        opc[k]   = op;
        wait_ready(k, {nm, "_grant"}, ok);
        if (ok) begin
            chk({nm, "_req_ready"}, 32'(ready), 32'(1 << k));
            @(posedge clk); #1;
            valid[k] = 1'b0;
            @(negedge clk);
            chk({nm, "_exec_no_valid"}, 32'(rsp_valid), 32'd0);
            @(negedge clk);
            chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({nm, "_rsp_data"}, rsp_data, exp_d);
            chk({nm, "_rsp_id"}, 32'(rsp_id), 32'(k));
            chk({nm, "_rsp_illegal"}, 32'(rsp_ill), 32'(exp_ill));
            @(posedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_order [5];
        int cnt;
        int gi;
        bit ok;

`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        rst       = 1'b1;
        rsp_ready = 1'b1;
        clear_reqs();
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        single(1, 32'd5, 32'd7, 4'd0, 32'd12, 1'b0, "add_5_7");

        single(0, 32'd3,          32'd5,  4'd1, 32'hFFFF_FFFE, 1'b0, "sub");
        single(0, 32'hFFFF_FFFF,  32'd1,  4'd2, 32'd1,         1'b0, "slt");
        single(0, 32'hFFFF_FFFF,  32'd1,  4'd3, 32'd0,         1'b0, "sltu");
        single(0, 32'h8000_0000,  32'd4,  4'd9, 32'hF800_0000, 1'b0, "sra");
        single(0, 32'h8000_0000,  32'd4,  4'd8, 32'h0800_0000, 1'b0, "srl");
        single(0, 32'd1,          32'd31, 4'd7, 32'h8000_0000, 1'b0, "sll");
        single(0, 32'h1234_5678,  32'd9,  4'd12, 32'd0,        1'b1, "illegal_op12");

        // Contention from a fresh reset so the pointer starts at 0.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < NR; k++) begin
            valid[k] = 1'b1;
            opa[k]   = 32'(100 * k + 1);
            opb[k]   = 32'(k);
            opc[k]   = 4'd0;
        end
        for (int n = 0; n < 5; n++) begin
            cnt = 0;
            ok  = 1'b0;
            while (!ok && cnt < 20) begin
                @(negedge clk);
                cnt++;
                if (|ready) ok = 1'b1;
            end
            if (!ok) tmo("contention_grant");
            else begin
                gi = -1;
                for (int k = NR - 1; k >= 0; k--) if (ready[k]) gi = k;
                chk("contention_grant_order", 32'(gi), 32'(exp_order[n]));
                if (n > 0) chk("contention_grant_spacing", 32'(cnt), 32'd3);
            end
        end
        @(posedge clk); #1;
        clear_reqs();
        wait_idle("contention_drain");

        // Backpressure: five stalled response cycles, competing request held meanwhile.
        @(posedge clk); #1;
        valid[2] = 1'b1; opa[2] = 32'd10; opb[2] = 32'd20; opc[2] = 4'd0;
        wait_ready(2, "bp_grant", ok);
        if (ok) begin
            chk("bp_req_ready", 32'(ready), 32'h4);
            @(posedge clk); #1;
            valid[2] = 1'b0;
            rsp_ready = 1'b0;
            valid[3] = 1'b1; opa[3] = 32'd1; opb[3] = 32'd2; opc[3] = 4'd0;
            @(negedge clk);
            chk("bp_exec_no_valid", 32'(rsp_valid), 32'd0);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("bp_rsp_data", rsp_data, 32'd30);
                chk("bp_rsp_id", 32'(rsp_id), 32'd2);
                chk("bp_req_ready_low", 32'(ready), 32'd0);
                chk("bp_busy", 32'(busy), 32'd1);
                @(posedge clk); #1;
                if (i == 4) rsp_ready = 1'b1;
            end
            @(negedge clk);
            chk("bp_hold_until_handshake", 32'(rsp_valid), 32'd1);
            @(negedge clk);
            chk("bp_next_grant", 32'(ready), 32'h8);
            @(posedge clk); #1;
            valid[3] = 1'b0;
            wait_idle("bp_drain");
        end

        // Reset during EXEC: everything clears and nothing is returned.
        @(posedge clk); #1;
        clear_reqs();
        valid[1] = 1'b1; opa[1] = 32'd7; opb[1] = 32'd8; opc[1] = 4'd0;
        wait_ready(1, "rst_mid_grant", ok);
        if (ok) begin
            @(posedge clk); #1;
            chk("rst_mid_busy_before", 32'(busy), 32'd1);
            rst = 1'b1;
            clear_reqs();
            #1;
            chk("rst_mid_busy", 32'(busy), 32'd0);
            chk("rst_mid_req_ready", 32'(ready), 32'd0);
            chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_mid_rsp_data", rsp_data, 32'd0);
            chk("rst_mid_rsp_id", 32'(rsp_id), 32'd0);
            chk("rst_mid_rsp_illegal", 32'(rsp_ill), 32'd0);
            @(posedge clk); #1 rst = 1'b0;
            repeat (4) begin
                @(negedge clk);
                chk("rst_mid_no_response", 32'(rsp_valid), 32'd0);
            end
            @(posedge clk); #1;
            valid[0] = 1'b1; opa[0] = 32'd2; opb[0] = 32'd3; opc[0] = 4'd7;
            valid[2] = 1'b1; opa[2] = 32'd9; opb[2] = 32'd9; opc[2] = 4'd0;
            wait_ready(0, "rst_after_grant", ok);
            if (ok) begin
                chk("rst_after_ptr_zero", 32'(ready), 32'h1);
                @(posedge clk); #1;
                clear_reqs();
                @(negedge clk);
                @(negedge clk);
                chk("rst_after_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rst_after_rsp_data", rsp_data, 32'd16);
                chk("rst_after_rsp_id", 32'(rsp_id), 32'd0);
                wait_idle("rst_after_drain");
            end
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
